// File: rtl/cop_regbank_pkg.sv
// rtl/cop_regbank_pkg.sv - shared control-register indices, bit positions and timer state encoding
package cop_regbank_pkg;

  localparam logic [4:0] C_CTRL   = 5'd0;
  localparam logic [4:0] C_STATUS = 5'd1;
  localparam logic [4:0] C_LIMIT  = 5'd2;
  localparam logic [4:0] C_COUNT  = 5'd3;

  localparam int B_START = 0;
  localparam int B_AUTO  = 1;
  localparam int B_STOP  = 2;
  localparam int B_BUSY  = 0;
  localparam int B_DONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2
  } state_t;

endpackage

// File: rtl/cop_timer.sv
// rtl/cop_timer.sv - interval timer FSM with CTRL/STATUS/LIMIT/COUNT registers
// Instantiated by cop_regbank only when COP_REGBANK_TIMER_EN is defined.
module cop_timer
  import cop_regbank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        wr_con,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        condinn,
  output logic        irq
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx, limit, limit_nx;
  logic             auto_q, auto_nx, done, done_nx, irq_nx, set_done;
  logic             ctrl_wr, start, stop, clr_done;

  assign ctrl_wr  = wr_con && (wr_addr == C_CTRL);
  assign start    = ctrl_wr && wr_data[B_START];
  assign stop     = ctrl_wr && wr_data[B_STOP];
  assign clr_done = wr_con && (wr_addr == C_STATUS) && wr_data[B_DONE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      limit  <= '0;
      auto_q <= 1'b0;
      done   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      limit  <= limit_nx;
      auto_q <= auto_nx;
      done   <= done_nx;
      irq    <= irq_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    limit_nx = limit;
    auto_nx  = auto_q;
    set_done = 1'b0;
    if (ctrl_wr) auto_nx = wr_data[B_AUTO];
    if (wr_con && (wr_addr == C_LIMIT)) limit_nx = wr_data[CNT_W-1:0];
    // STOP beats START; a (re)start with LIMIT=0 completes immediately without running
    if (stop) begin
      state_nx = ST_IDLE;
    end else if (start) begin
      if (limit != '0) begin
        count_nx = limit;
        state_nx = ST_RUN;
      end else begin
        set_done = 1'b1;
        state_nx = ST_IDLE;
      end
    end else begin
      unique case (state)
        ST_RUN: begin
          if (!hold) begin
            if (count == CNT_W'(1)) begin
              count_nx = '0;
              set_done = 1'b1;
              state_nx = ST_EXPIRE;
            end else begin
              count_nx = count - CNT_W'(1);
            end
          end
        end
        ST_EXPIRE: begin
          if (auto_q && (limit != '0)) begin
            count_nx = limit;
            state_nx = ST_RUN;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
    // a set landing together with the W1C clear wins
    done_nx = set_done | (done & ~clr_done);
    irq_nx  = set_done;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      C_CTRL:   rd_data[B_AUTO] = auto_q;
      C_STATUS: begin
        rd_data[B_BUSY] = (state != ST_IDLE);
        rd_data[B_DONE] = done;
      end
      C_LIMIT:  rd_data[CNT_W-1:0] = limit;
      C_COUNT:  rd_data[CNT_W-1:0] = count;
      default:  rd_data = '0;
    endcase
  end

  assign condinn = ~done;

endmodule

// File: rtl/cop_regbank.sv
// rtl/cop_regbank.sv - coprocessor register bank: general registers, read mux, optional timer
// The timer and control registers exist only when COP_REGBANK_TIMER_EN is defined.
module cop_regbank
  import cop_regbank_pkg::*;
#(
  parameter int GEN_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic        SYSCLK,
  input  logic        RESET_D1_R_N,
  input  logic        RHOLD,
  input  logic [4:0]  CRDADDR,
  input  logic        CRDGEN,
  input  logic        CRDCON,
  output logic [31:0] CRDDATA,
  input  logic [4:0]  CWRADDR_R,
  input  logic        CWRGEN_R,
  input  logic        CWRCON_R,
  input  logic [31:0] CWRDATA_R,
  output logic        CONDINN,
  output logic        TIMER_IRQ_R
);

  localparam int AW = (GEN_REGS > 1) ? $clog2(GEN_REGS) : 1;

  logic [31:0] g_regs [GEN_REGS];
  logic [31:0] con_rdata;
  logic        rd_hit, wr_hit;

  assign rd_hit = ({1'b0, CRDADDR} < 6'(GEN_REGS));
  assign wr_hit = ({1'b0, CWRADDR_R} < 6'(GEN_REGS));

  always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      for (int i = 0; i < GEN_REGS; i++) g_regs[i] <= '0;
    end else if (CWRGEN_R && wr_hit) begin
      g_regs[CWRADDR_R[AW-1:0]] <= CWRDATA_R;
    end
  end

  // General read wins when both selects are high
  always_comb begin
    CRDDATA = '0;
    if (CRDGEN) begin
      if (rd_hit) CRDDATA = g_regs[CRDADDR[AW-1:0]];
    end else if (CRDCON) begin
      CRDDATA = con_rdata;
    end
  end

`ifdef COP_REGBANK_TIMER_EN
  cop_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (SYSCLK),
    .rst_n   (RESET_D1_R_N),
    .hold    (RHOLD),
    .wr_con  (CWRCON_R),
    .wr_addr (CWRADDR_R),
    .wr_data (CWRDATA_R),
    .rd_addr (CRDADDR),
    .rd_data (con_rdata),
    .condinn (CONDINN),
    .irq     (TIMER_IRQ_R)
  );
`else
  logic unused_timer_inputs;
  assign unused_timer_inputs = ^{RHOLD, CWRCON_R};
  assign con_rdata   = '0;
  assign CONDINN     = 1'b1;
  assign TIMER_IRQ_R = 1'b0;
`endif

endmodule

// File: tb/tb_cop_regbank.sv
// tb/tb_cop_regbank.sv - scoreboard bench for cop_regbank against a behavioural model
// Timer expectations apply when COP_REGBANK_TIMER_EN is defined; otherwise control space reads 0.
module tb_cop_regbank;

  logic        SYSCLK = 1'b0;
  logic        RESET_D1_R_N = 1'b0;
  logic        RHOLD = 1'b0;
  logic [4:0]  CRDADDR = '0;
  logic        CRDGEN = 1'b0;
  logic        CRDCON = 1'b0;
  logic [31:0] CRDDATA;
  logic [4:0]  CWRADDR_R = '0;
  logic        CWRGEN_R = 1'b0;
  logic        CWRCON_R = 1'b0;
  logic [31:0] CWRDATA_R = '0;
  logic        CONDINN;
  logic        TIMER_IRQ_R;

  cop_regbank #(.GEN_REGS(32), .CNT_W(32)) dut (
    .SYSCLK(SYSCLK), .RESET_D1_R_N(RESET_D1_R_N), .RHOLD(RHOLD),
    .CRDADDR(CRDADDR), .CRDGEN(CRDGEN), .CRDCON(CRDCON), .CRDDATA(CRDDATA),
    .CWRADDR_R(CWRADDR_R), .CWRGEN_R(CWRGEN_R), .CWRCON_R(CWRCON_R), .CWRDATA_R(CWRDATA_R),
    .CONDINN(CONDINN), .TIMER_IRQ_R(TIMER_IRQ_R)
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: what software would see in each register
  logic [31:0] m_g [32];
  logic [31:0] m_limit, m_count;
  logic        m_auto, m_done, m_busy, m_exp, m_irq;

  typedef struct packed {
    logic [31:0] d;
    logic        cn;
    logic        irq;
  } exp_t;
  exp_t sbq[$];
  logic [31:0] mask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_g[i] = '0;
    m_limit = '0; m_count = '0;
    m_auto = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_exp = 1'b0; m_irq = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic rg, input logic rc, input logic [4:0] ra);
    if (rg) return m_g[ra];
`ifdef COP_REGBANK_TIMER_EN
    if (rc) begin
      case (ra)
        5'd0: return {30'b0, m_auto, 1'b0};
        5'd1: return {30'b0, m_done, m_busy};
        5'd2: return m_limit;
        5'd3: return m_count;
        default: return 32'h0;
      endcase
    end
`endif
    return 32'h0;
  endfunction

  function automatic logic m_condinn();
`ifdef COP_REGBANK_TIMER_EN
    return ~m_done;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic m_irq_out();
`ifdef COP_REGBANK_TIMER_EN
    return m_irq;
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge of the model, using register contents from before the edge
  function automatic void m_step(input logic h, input logic wg, input logic wc,
                                 input logic [4:0] wa, input logic [31:0] wd);
    logic start, stop, clr, fire;
    logic [31:0] lim;
    logic au;
    if (wg) m_g[wa] = wd;
`ifdef COP_REGBANK_TIMER_EN
    start = wc && wa == 5'd0 && wd[0];
    stop  = wc && wa == 5'd0 && wd[2];
    clr   = wc && wa == 5'd1 && wd[1];
    lim = m_limit; au = m_auto; fire = 1'b0;
    if (stop) begin
      m_busy = 1'b0; m_exp = 1'b0;
    end else if (start) begin
      m_exp = 1'b0;
      if (lim == 0) begin fire = 1'b1; m_busy = 1'b0; end
      else begin m_count = lim; m_busy = 1'b1; end
    end else if (m_exp) begin
      m_exp = 1'b0;
      if (au && lim != 0) m_count = lim;
      else m_busy = 1'b0;
    end else if (m_busy && !h) begin
      m_count = m_count - 1;
      if (m_count == 0) begin fire = 1'b1; m_exp = 1'b1; end
    end
    if (clr) m_done = 1'b0;
    if (fire) m_done = 1'b1;
    m_irq = fire;
    if (wc && wa == 5'd0) m_auto = wd[1];
    if (wc && wa == 5'd2) m_limit = wd;
`else
    start = wc; stop = h; clr = 1'b0; fire = 1'b0; lim = 32'h0; au = 1'b0;
`endif
  endfunction

  // Drive one cycle; the expected read/flags for this cycle go to the scoreboard
  task automatic cyc(input logic h, input logic wg, input logic wc, input logic [4:0] wa,
                     input logic [31:0] wd, input logic rg, input logic rc, input logic [4:0] ra);
    exp_t e;
    RHOLD = h; CWRGEN_R = wg; CWRCON_R = wc; CWRADDR_R = wa; CWRDATA_R = wd;
    CRDGEN = rg; CRDCON = rc; CRDADDR = ra;
    e.d = m_read(rg, rc, ra);
    e.cn = m_condinn();
    e.irq = m_irq_out();
    sbq.push_back(e);
    @(posedge SYSCLK);
    #1;
    m_step(h, wg, wc, wa, wd);
  endtask

  task automatic idle(input logic h);
    cyc(h, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd1);
  endtask

  task automatic wcon(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, 1'b1, a, d, 1'b0, 1'b1, 5'd3);
  endtask

  task automatic peek(input logic rg, input logic rc, input logic [4:0] ra,
                      input string nm, input logic [31:0] exp);
    CRDGEN = rg; CRDCON = rc; CRDADDR = ra;
    #1;
    chk(nm, CRDDATA, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge SYSCLK);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_crddata", CRDDATA, e.d);
        chk("sb_condinn", {31'b0, CONDINN}, {31'b0, e.cn});
        chk("sb_irq", {31'b0, TIMER_IRQ_R}, {31'b0, e.irq});
      end
    end
  end

  initial begin : stim
    logic [4:0] a;
    m_reset();
    #2;
    peek(1'b1, 1'b0, 5'd5, "reset_gen_read", 32'h0);
    peek(1'b0, 1'b1, 5'd1, "reset_status_read", 32'h0);
    chk("reset_condinn", {31'b0, CONDINN}, 32'h1);
    chk("reset_irq", {31'b0, TIMER_IRQ_R}, 32'h0);
    #8 RESET_D1_R_N = 1'b1;
    @(posedge SYSCLK); #1;

    // general register: same-edge read sees old value, next cycle sees new
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd5);
    peek(1'b1, 1'b0, 5'd5, "g5_readback", 32'hDEADBEEF);
    peek(1'b1, 1'b1, 5'd5, "gen_wins_over_con", 32'hDEADBEEF);

`ifdef COP_REGBANK_TIMER_EN
    // basic: LIMIT=3
    wcon(5'd2, 32'd3);
    wcon(5'd0, 32'h1);
    peek(1'b0, 1'b1, 5'd1, "basic_busy_after_start", 32'h1);
    peek(1'b0, 1'b1, 5'd3, "basic_count_loaded", 32'h3);
    idle(1'b0); idle(1'b0);
    chk("basic_no_irq_early", {31'b0, TIMER_IRQ_R}, 32'h0);
    idle(1'b0);
    peek(1'b0, 1'b1, 5'd1, "basic_done_at_n3", 32'h3);
    chk("basic_condinn_low", {31'b0, CONDINN}, 32'h0);
    chk("basic_irq_at_n3", {31'b0, TIMER_IRQ_R}, 32'h1);
    idle(1'b0);
    peek(1'b0, 1'b1, 5'd1, "basic_idle_at_n4", 32'h2);
    wcon(5'd1, 32'h2);
    chk("w1c_condinn_high", {31'b0, CONDINN}, 32'h1);

    // RHOLD: LIMIT=4, two held cycles
    wcon(5'd2, 32'd4);
    wcon(5'd0, 32'h1);
    idle(1'b0); idle(1'b1); idle(1'b1); idle(1'b0); idle(1'b0);
    chk("hold_no_irq_n5", {31'b0, TIMER_IRQ_R}, 32'h0);
    idle(1'b0);
    chk("hold_irq_n6", {31'b0, TIMER_IRQ_R}, 32'h1);
    chk("hold_condinn_n6", {31'b0, CONDINN}, 32'h0);
    wcon(5'd1, 32'h2);
    chk("hold_w1c_condinn", {31'b0, CONDINN}, 32'h1);

    // auto-reload: LIMIT=2
    wcon(5'd2, 32'd2);
    wcon(5'd0, 32'h3);
    mask = '0;
    for (int k = 1; k <= 9; k++) begin
      idle(1'b0);
      if (TIMER_IRQ_R) mask[k] = 1'b1;
    end
    chk("auto_irq_edges", mask, 32'h124);
    wcon(5'd0, 32'h6);
    peek(1'b0, 1'b1, 5'd3, "stop_count_held", 32'h2);
    peek(1'b0, 1'b1, 5'd1, "stop_idle_done", 32'h2);
    wcon(5'd0, 32'h0);
    wcon(5'd1, 32'h2);

    // LIMIT=0 start
    wcon(5'd2, 32'd0);
    wcon(5'd0, 32'h1);
    peek(1'b0, 1'b1, 5'd1, "limit0_done_idle", 32'h2);
    chk("limit0_irq", {31'b0, TIMER_IRQ_R}, 32'h1);
    wcon(5'd1, 32'h2);

    // START and STOP together
    wcon(5'd2, 32'd5);
    wcon(5'd0, 32'h5);
    peek(1'b0, 1'b1, 5'd1, "start_stop_idle", 32'h0);

    // expiry coincides with W1C
    wcon(5'd2, 32'd1);
    wcon(5'd0, 32'h1);
    wcon(5'd1, 32'h2);
    peek(1'b0, 1'b1, 5'd1, "set_beats_clear", 32'h3);
    idle(1'b0);
    wcon(5'd1, 32'h2);
`else
    wcon(5'd2, 32'h10);
    peek(1'b0, 1'b1, 5'd2, "nomacro_limit_reads0", 32'h0);
    chk("nomacro_condinn", {31'b0, CONDINN}, 32'h1);
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      a = 5'($urandom);
      case ($urandom % 8)
        0, 1, 2: cyc(($urandom % 4) == 0, 1'b1, 1'b0, a, $urandom,
                     1'($urandom), 1'($urandom), 5'($urandom));
        3: cyc(($urandom % 4) == 0, 1'b0, 1'b1, 5'd2, $urandom_range(0, 5),
               1'($urandom), 1'($urandom), 5'($urandom % 6));
        4: cyc(($urandom % 4) == 0, 1'b0, 1'b1, 5'd0, $urandom,
               1'b0, 1'b1, 5'($urandom % 4));
        5: cyc(($urandom % 4) == 0, 1'b0, 1'b1, 5'd1, $urandom,
               1'b0, 1'b1, 5'($urandom % 4));
        6: cyc(($urandom % 4) == 0, 1'($urandom), 1'b1, (a == 5'd2) ? 5'd3 : a, $urandom,
               1'($urandom), 1'($urandom), 5'($urandom));
        default: cyc(($urandom % 4) == 0, 1'b0, 1'b0, a, $urandom,
                     1'($urandom), 1'($urandom), 5'($urandom));
      endcase
    end

    // reset mid-RUN with COUNT=7
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 32'h5555AAAA, 1'b0, 1'b0, 5'd0);
    wcon(5'd0, 32'h4);
    wcon(5'd2, 32'd10);
    wcon(5'd0, 32'h1);
    idle(1'b0); idle(1'b0); idle(1'b0);
    peek(1'b0, 1'b1, 5'd3, "pre_reset_count", m_read(1'b0, 1'b1, 5'd3));
    #1 RESET_D1_R_N = 1'b0;
    peek(1'b0, 1'b1, 5'd3, "reset_count_cleared", 32'h0);
    peek(1'b1, 1'b0, 5'd5, "reset_g5_cleared", 32'h0);
    chk("reset_mid_condinn", {31'b0, CONDINN}, 32'h1);
    #2 RESET_D1_R_N = 1'b1;
    m_reset();
    for (int n = 0; n < 20; n++)
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'($urandom), 1'b1, 5'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cop_regbank.md
# cop_regbank

Coprocessor register bank for a coprocessor slot, directly downstream of the coprocessor interface logic. It holds 32 general registers and a small control-register space, and serves the interface's read port (CRDADDR/CRDGEN/CRDCON to CRDDATA) and its registered write-back port. A built-in interval timer FSM drives the active-low branch condition CONDINN back to the interface.

## Interface
- `GEN_REGS`, 32: number of general registers; must be a power of two, max 32. Addresses at or above GEN_REGS read 0 and ignore writes.
- `CNT_W`, 32: timer counter width; must be ≤ 32. Zero-extended on reads.

Ports:
- `SYSCLK` in, 1: the block's only clock.
- `RESET_D1_R_N` in, 1: asynchronous, active-low reset.
- `RHOLD` in, 1: pipeline hold; the timer does not decrement while high.
- `CRDADDR` in, 5: read address.
- `CRDGEN` in, 1: read from a general register.
- `CRDCON` in, 1: read from a control register.
- `CRDDATA` out, 32: read data, combinational.
- `CWRADDR_R` in, 5: write address.
- `CWRGEN_R` in, 1: write strobe for a general register.
- `CWRCON_R` in, 1: write strobe for a control register.
- `CWRDATA_R` in, 32: write data.
- `CONDINN` out, 1: condition flag, active low; equals ~DONE.
- `TIMER_IRQ_R` out, 1: one-cycle pulse on timer expiry.

## Operation
Reads:
- `CRDDATA` is G[CRDADDR] if CRDGEN, otherwise C[CRDADDR] if CRDCON, otherwise 0.
- If CRDGEN and CRDCON are both high, the general-register read wins.
- A read of an address written at the same edge returns the old value. Upstream handles the bypass.

Writes:
- Writes take effect at posedge SYSCLK. They are not gated by RHOLD, because upstream already qualifies the strobes.

Control registers:
- C0 CTRL:
  - bit0 START: write-1 pulse; always reads 0.
  - bit1 AUTO: reload on expiry.
  - bit2 STOP: write-1 pulse; always reads 0.
- C1 STATUS:
  - bit0 BUSY: read-only.
  - bit1 DONE: sticky; writing 1 to bit1 clears it.
- C2 LIMIT: read/write, CNT_W bits.
- C3 COUNT: read-only; writes are ignored.
- C4..C31: read 0; writes are ignored.

Timer FSM has three states: IDLE, RUN, EXPIRE.
- IDLE:
  - START with LIMIT≠0: COUNT←LIMIT, go to RUN.
  - START with LIMIT=0: DONE←1, pulse IRQ, stay in IDLE.
- RUN:
  - When !RHOLD: COUNT←COUNT−1.
  - When COUNT=1 and !RHOLD: COUNT←0, DONE←1, go to EXPIRE.
  - STOP: go to IDLE; COUNT and DONE hold their values.
  - START: COUNT←LIMIT, stay in RUN (restart).
- EXPIRE (lasts one cycle; TIMER_IRQ_R=1):
  - AUTO=1 and LIMIT≠0: COUNT←LIMIT, go to RUN.
  - Otherwise: go to IDLE.
  - EXPIRE is not stalled by RHOLD.
- BUSY = (state≠IDLE).
- If START and STOP are written together, STOP wins.
- If DONE is set and a W1C clear lands in the same cycle, set wins.

Reset values:
- All G and C registers are 0; state is IDLE; COUNT is 0.
- CONDINN=1, TIMER_IRQ_R=0.
- CRDDATA is 0 for any read.
- Reset asserted mid-RUN aborts to IDLE immediately (asynchronously).

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- START written at edge N: BUSY=1 and COUNT=LIMIT are visible after edge N.
- With no RHOLD, DONE rises and CONDINN falls at edge N+LIMIT. TIMER_IRQ_R is high during cycle N+LIMIT.
- Each RHOLD cycle in RUN delays expiry by one cycle.
- CONDINN is a direct inversion of the DONE flop: glitch-free and registered.

## Configuration
- `COP_REGBANK_TIMER_EN` defined: the timer FSM and C0..C3 behave as described above.
- Not defined:
  - No FSM or counter logic is generated.
  - C0..C31 all read 0 and ignore writes.
  - CONDINN is tied to 1 and TIMER_IRQ_R to 0.
  - The general-register behaviour is unchanged.

## Structure
- Shared package `cop_regbank_pkg` holds:
  - control-register indices (C_CTRL=0, C_STATUS=1, C_LIMIT=2, C_COUNT=3);
  - bit positions (START, AUTO, STOP, BUSY, DONE);
  - the FSM state encoding (IDLE, RUN, EXPIRE).
- One sub-module, `cop_timer`, contains the FSM, COUNT, LIMIT, AUTO and DONE. It is instantiated only under COP_REGBANK_TIMER_EN.
- The general register array and the read mux stay in the top level.

## Test plan
- **General-register write/read:** write G5=0xDEADBEEF, then CRDGEN=1, CRDADDR=5 on the next cycle → CRDDATA=0xDEADBEEF. A read at the same edge as the write returns the old value, 0.
- **Basic timer:** LIMIT=3, START at edge N → BUSY=1 after N; DONE=1, CONDINN=0 and TIMER_IRQ_R pulse at N+3; BUSY=0 at N+4.
- **RHOLD during RUN:** LIMIT=4 with RHOLD high for 2 cycles during RUN → expiry at N+6. Then W1C of C1 bit1 → CONDINN=1 on the next cycle.
- **Auto-reload:** AUTO=1, LIMIT=2 → IRQ pulses at N+2, N+5 and N+8. STOP then returns to IDLE with COUNT held.
- **Edge cases:**
  - LIMIT=0 with START → DONE=1 after one edge; state stays IDLE.
  - START and STOP together → stays IDLE.
  - Expiry coinciding with a DONE clear → DONE=1.
- **Reset mid-RUN and macro off:**
  - Asserting RESET_D1_R_N low while COUNT=7 → immediately COUNT=0, CONDINN=1, all G registers 0.
  - Build without the macro → C2 read returns 0 after writing 0x10; CONDINN constant 1.
